// File: rtl/vector_square_mul_pipe.sv
// vector_square_mul_pipe: multi-lane 2-stage pipelined square/multiply on packed {sign, mantissa, exponent} words
module vector_square_mul_pipe #(
  parameter int WORD_W = 24,
  parameter int EXP_W  = 8,
  parameter int MANT_W = 15,
  parameter int LANES  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      mode,
  input  logic [LANES*WORD_W-1:0]   data_a,
  input  logic [LANES*WORD_W-1:0]   data_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*WORD_W-1:0]   data_out,
  output logic [LANES-1:0]          ovf,
  output logic                      ovf_sticky,
  input  logic                      ovf_clr
);
  localparam int PW = 2*MANT_W;
  localparam int EW = EXP_W+2;
  logic                    advance, v1;
  logic [MANT_W-1:0]       ph_n [LANES];
  logic [MANT_W-1:0]       ph   [LANES];
  logic [EW-1:0]           e_n  [LANES];
  logic [EW-1:0]           e1   [LANES];
  logic [LANES-1:0]        s_n, s1, z_n, z1, ovf_n;
  logic [LANES*WORD_W-1:0] res;
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;
  // Only the upper half of the product survives truncation, so stage 1 keeps just that plus a zero flag
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [WORD_W-1:0] wa, wb;
    logic [PW-1:0]     p;
    logic              sat;
    assign wa      = data_a[g*WORD_W +: WORD_W];
    assign wb      = mode ? data_b[g*WORD_W +: WORD_W] : wa;
    assign p       = PW'(wa[WORD_W-2:EXP_W]) * PW'(wb[WORD_W-2:EXP_W]);
    assign ph_n[g] = p[PW-1:MANT_W];
    assign z_n[g]  = p == '0;
    assign e_n[g]  = EW'(wa[EXP_W-1:0]) + EW'(wb[EXP_W-1:0]) + EW'(MANT_W);
    assign s_n[g]  = mode & (wa[WORD_W-1] ^ wb[WORD_W-1]);
    assign sat     = |e1[g][EW-1:EXP_W];
    assign ovf_n[g] = ~z1[g] & sat;
    assign res[g*WORD_W +: WORD_W] = z1[g] ? '0 :
                                     sat   ? {s1[g], {(WORD_W-1){1'b1}}} :
                                             {s1[g], ph[g], e1[g][EXP_W-1:0]};
  end
  // Both stages advance together; on stall everything holds, and output payload only changes with a real result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      ph        <= '{default: '0};
      e1        <= '{default: '0};
      s1        <= '0;
      z1        <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
      ovf       <= '0;
    end else if (advance) begin
      v1        <= in_valid;
      out_valid <= v1;
      if (in_valid) begin
        ph <= ph_n;
        e1 <= e_n;
        s1 <= s_n;
        z1 <= z_n;
      end
      if (v1) begin
        data_out <= res;
        ovf      <= ovf_n;
      end
    end
  end
  // Sticky overflow: a transferred overflow beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_sticky <= 1'b0;
    else if (out_valid & out_ready & |ovf) ovf_sticky <= 1'b1;
    else if (ovf_clr) ovf_sticky <= 1'b0;
  end
endmodule

// File: doc/vector_square_mul_pipe.md
Name: vector_square_mul_pipe

Overview:
- Multi-lane, 2-stage pipelined square/multiply unit for the vector machine datapath.
- Operates on the machine's packed float word {sign, mantissa, exponent}.
- Each lane returns either the square of operand A or the product A*B.
- Uses a valid/ready handshake, overflow saturation, a per-lane overflow flag and a sticky overflow status.

Parameters:
- WORD_W, 24, total word width; equals 1+MANT_W+EXP_W.
- EXP_W, 8, exponent field width in bits [EXP_W-1:0], unsigned.
- MANT_W, 15, mantissa field width in bits [WORD_W-2:EXP_W], unsigned integer.
- LANES, 4, number of independent lanes; lane i occupies bits [i*WORD_W +: WORD_W].

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word set valid.
- in_ready  out  1  unit accepts input this cycle.
- mode  in  1  0 = square A, 1 = multiply A*B; sampled with input.
- data_a  in  LANES*WORD_W  operand A lanes.
- data_b  in  LANES*WORD_W  operand B lanes; ignored when mode=0.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- data_out  out  LANES*WORD_W  result lanes.
- ovf  out  LANES  per-lane overflow, aligned with data_out.
- ovf_sticky  out  1  OR of all ovf bits seen since reset or clear.
- ovf_clr  in  1  synchronous clear of ovf_sticky.

Behaviour:
- Reset is asynchronous on rst_n low. On reset:
  - all stage valids = 0
  - out_valid = 0
  - data_out = 0
  - ovf = 0
  - ovf_sticky = 0
  - in_ready = 1 after reset
- Pipeline and handshake:
  - advance = ~out_valid | out_ready, and in_ready = advance.
  - Both stages move together only on advance. On stall, every stage register holds its value.
  - Transfer in occurs when in_valid & in_ready. Transfer out occurs when out_valid & out_ready.
  - Latency is exactly 2 cycles from input transfer to out_valid with no stall. Throughput is 1 set per cycle.
  - When a stage is empty, its bubble propagates as valid=0.
  - data_out and ovf keep their last value while out_valid=0.
- Stage 1, per lane:
  - P = Ma*Mb (2*MANT_W bits), with Mb = Ma when mode=0.
  - Esum = Ea+Eb+MANT_W (EXP_W+2 bits), with Eb = Ea when mode=0.
  - sign = mode ? Sa^Sb : 0.
  - Stage 1 registers P, Esum, sign and a zero flag.
- Stage 2, per lane, in priority order:
  - P==0: result = all-zero word (sign 0, exponent 0), ovf = 0.
  - Esum > 2^EXP_W-1: saturate. Mantissa is all ones, exponent is all ones, sign is kept, ovf = 1.
  - Otherwise: mantissa = P[2*MANT_W-1:MANT_W] (truncation, no rounding, no normalisation) and exponent = Esum[EXP_W-1:0].
- ovf_sticky:
  - Set on any output transfer with |ovf.
  - ovf_clr clears it. If clear and set happen in the same cycle, set wins.
- Lanes are fully independent; one lane saturating does not affect the others.
- If rst_n is asserted mid-stream, in-flight data is discarded and no partial result is presented.

Test Plan (LANES=4, defaults):
1. Square, no stall, all lanes = 0x400003 (M=0x4000, E=3), out_ready=1 -> 2 cycles later out_valid=1, every lane 0x200015, ovf=0000.
2. Multiply, lane0 A=0x7FFF01, B=0x000200, other lanes A=B=0 -> lane0 0x000110, lanes1-3 0x000000, ovf=0000.
3. Overflow, square of lane2 = 0x7FFF79 (E=121, Esum=257) -> lane2 0x7FFFFF, ovf=0100, ovf_sticky rises after transfer. Then ovf_clr pulse -> ovf_sticky=0.
4. Sign in multiply mode, A=0x800000|0x400003, B=0x400003 -> 0xA00015. Same A in square mode -> 0x200015.
5. Backpressure:
   - Push 3 back-to-back sets with out_ready=0 -> in_ready drops after the pipe fills, and the first result is held stable.
   - Release out_ready -> results emerge in order, none lost or duplicated.
6. Pull rst_n low while 2 sets are in flight -> out_valid=0, data_out=0, ovf_sticky=0 immediately. After release, a new set completes in 2 cycles.
